// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and the data cache port: word-aligned reads/writes,
// load extension, sub-word stores as read-modify-write. Optional MAU_WORD_BUF_EN adds a last-word buffer.
module mem_access_unit #(
  parameter int unsigned CORE_ADDR_WIDTH = 32,
  parameter int unsigned CORE_DATA_WIDTH = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [CORE_ADDR_WIDTH-1:0] req_addr,
  input  logic [CORE_DATA_WIDTH-1:0] req_wdata,
  output logic                       resp_valid,
  output logic [CORE_DATA_WIDTH-1:0] resp_rdata,
  output logic                       resp_err,
  output logic [CORE_ADDR_WIDTH-1:0] core_ARADDR,
  output logic                       core_ARVALID,
  input  logic [CORE_DATA_WIDTH-1:0] core_RDATA,
  input  logic                       core_RVALID,
  output logic [CORE_ADDR_WIDTH-1:0] core_AWADDR,
  output logic                       core_AWVALID,
  output logic [CORE_DATA_WIDTH-1:0] core_WDATA,
  input  logic                       core_BVALID
);

  localparam int unsigned AW = CORE_ADDR_WIDTH;
  localparam int unsigned DW = CORE_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] store_q;

  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  // Misaligned access or funct3 outside the legal load/store set.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic e;
    e = 1'b1;
    case (f3)
      3'b000:         e = 1'b0;
      3'b001:         e = lo[0];
      3'b010:         e = (lo != 2'b00);
      3'b100, 3'b101: e = we | (f3[0] & lo[0]);
      default:        e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [DW-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [DW-1:0] w);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overlay the store byte/half onto the fetched word at its lane.
  function automatic logic [DW-1:0] merge(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [DW-1:0] w, input logic [15:0] d);
    logic [DW-1:0] r;
    r = w;
    if (f3[1:0] == 2'b00) begin
      case (lo)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (lo[1]) begin
      r[31:16] = d;
    end else begin
      r[15:0] = d;
    end
    return r;
  endfunction

`ifdef MAU_WORD_BUF_EN
  logic          buf_valid;
  logic [AW-3:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic          buf_hit_c;

  assign buf_hit_c = buf_valid && (buf_addr == req_addr[AW-1:2]);
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      store_q      <= 16'd0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      core_ARADDR  <= '0;
      core_ARVALID <= 1'b0;
      core_AWADDR  <= '0;
      core_AWVALID <= 1'b0;
      core_WDATA   <= '0;
`ifdef MAU_WORD_BUF_EN
      buf_valid    <= 1'b0;
      buf_addr     <= '0;
      buf_data     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            store_q   <= req_wdata[15:0];
            if (access_err(req_we, req_funct3, req_addr[1:0])) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else if (!req_we) begin
`ifdef MAU_WORD_BUF_EN
              if (buf_hit_c) begin
                resp_valid <= 1'b1;
                resp_rdata <= load_ext(req_funct3, req_addr[1:0], buf_data);
                state      <= RESP;
              end else
`endif
              begin
                core_ARVALID <= 1'b1;
                core_ARADDR  <= word_addr(req_addr);
                state        <= RD;
              end
            end else if (req_funct3 == 3'b010) begin
              core_AWVALID <= 1'b1;
              core_AWADDR  <= word_addr(req_addr);
              core_WDATA   <= req_wdata;
              state        <= WR;
            end else begin
`ifdef MAU_WORD_BUF_EN
              if (buf_hit_c) begin
                core_AWVALID <= 1'b1;
                core_AWADDR  <= word_addr(req_addr);
                core_WDATA   <= merge(req_funct3, req_addr[1:0], buf_data, req_wdata[15:0]);
                state        <= WR;
              end else
`endif
              begin
                core_ARVALID <= 1'b1;
                core_ARADDR  <= word_addr(req_addr);
                state        <= RMW_RD;
              end
            end
          end
        end
        RD: begin
          if (core_RVALID) begin
            core_ARVALID <= 1'b0;
            core_ARADDR  <= '0;
            resp_valid   <= 1'b1;
            resp_rdata   <= load_ext(funct3_q, addr_lo_q, core_RDATA);
            state        <= RESP;
`ifdef MAU_WORD_BUF_EN
            buf_valid    <= 1'b1;
            buf_addr     <= core_ARADDR[AW-1:2];
            buf_data     <= core_RDATA;
`endif
          end
        end
        RMW_RD: begin
          if (core_RVALID) begin
            core_ARVALID <= 1'b0;
            core_ARADDR  <= '0;
            core_AWVALID <= 1'b1;
            core_AWADDR  <= core_ARADDR;
            core_WDATA   <= merge(funct3_q, addr_lo_q, core_RDATA, store_q);
            state        <= WR;
`ifdef MAU_WORD_BUF_EN
            buf_valid    <= 1'b1;
            buf_addr     <= core_ARADDR[AW-1:2];
            buf_data     <= core_RDATA;
`endif
          end
        end
        WR: begin
          if (core_BVALID) begin
            core_AWVALID <= 1'b0;
            core_AWADDR  <= '0;
            core_WDATA   <= '0;
            resp_valid   <= 1'b1;
            state        <= RESP;
`ifdef MAU_WORD_BUF_EN
            buf_valid    <= 1'b1;
            buf_addr     <= core_AWADDR[AW-1:2];
            buf_data     <= core_WDATA;
`endif
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default build, no word buffer).
module tb_mem_access_unit;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] core_ARADDR;
  logic        core_ARVALID;
  logic [31:0] core_RDATA = 32'd0;
  logic        core_RVALID = 1'b0;
  logic [31:0] core_AWADDR;
  logic        core_AWVALID;
  logic [31:0] core_WDATA;
  logic        core_BVALID = 1'b0;

  int errors = 0;
  int checks = 0;
  logic both_seen = 1'b0;

  mem_access_unit dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .core_ARADDR(core_ARADDR), .core_ARVALID(core_ARVALID),
    .core_RDATA(core_RDATA), .core_RVALID(core_RVALID),
    .core_AWADDR(core_AWADDR), .core_AWVALID(core_AWVALID),
    .core_WDATA(core_WDATA), .core_BVALID(core_BVALID)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (core_ARVALID && core_AWVALID) both_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    tick(); tick();
    ARESET = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if ({core_ARVALID, core_AWVALID, resp_valid, resp_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_valids: got %b expected 0000", {core_ARVALID, core_AWVALID, resp_valid, resp_err}); end
    checks++; if ({core_ARADDR, core_AWADDR, core_WDATA, resp_rdata} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {core_ARADDR, core_AWADDR, core_WDATA, resp_rdata}); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3  [7] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010, 3'b000, 3'b001};
    logic [31:0] adr [7] = '{32'h103, 32'h102, 32'h102, 32'h501, 32'h600, 32'h700, 32'h800};
    logic [31:0] rd  [7] = '{32'h80FF_1234, 32'hBEEF_0001, 32'hBEEF_0001, 32'h80FF_1234,
                             32'hCAFE_F00D, 32'h0000_007F, 32'h0000_8001};
    logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_0012,
                             32'hCAFE_F00D, 32'h0000_007F, 32'hFFFF_8001};
    logic [31:0] exp_ar;
    for (int i = 0; i < 7; i++) begin
      exp_ar = adr[i] & 32'hFFFF_FFFC;
      issue(1'b0, f3[i], adr[i], 32'd0);
      checks++; if ({core_ARVALID, core_AWVALID, req_ready, core_ARADDR} !== {3'b100, exp_ar}) begin
        errors++; $display("FAIL load%0d_ar: got %b%b%b %h expected 100 %h", i,
                           core_ARVALID, core_AWVALID, req_ready, core_ARADDR, exp_ar); end
      tick();
      checks++; if ({core_ARVALID, resp_valid, core_ARADDR} !== {2'b10, exp_ar}) begin
        errors++; $display("FAIL load%0d_hold: got %b%b %h expected 10 %h", i,
                           core_ARVALID, resp_valid, core_ARADDR, exp_ar); end
      core_RVALID = 1'b1; core_RDATA = rd[i];
      tick();
      core_RVALID = 1'b0; core_RDATA = 32'h5A5A_5A5A;
      checks++; if ({resp_valid, resp_err, core_ARVALID, resp_rdata} !== {3'b100, exp[i]}) begin
        errors++; $display("FAIL load%0d_resp: got %b%b%b %h expected 100 %h", i,
                           resp_valid, resp_err, core_ARVALID, resp_rdata, exp[i]); end
      tick();
      checks++; if ({resp_valid, req_ready, core_ARADDR} !== {2'b01, 32'd0}) begin
        errors++; $display("FAIL load%0d_idle: got %b%b %h expected 01 0", i, resp_valid, req_ready, core_ARADDR); end
    end
  endtask

  task automatic test_subword_rmw;
    logic        sz  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] adr [3] = '{32'h201, 32'h302, 32'h403};
    logic [31:0] wd  [3] = '{32'hFFFF_FFAA, 32'h1234_5566, 32'h0000_0001};
    logic [31:0] rd  [3] = '{32'h1122_3344, 32'h1122_3344, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h1122_AA44, 32'h5566_3344, 32'h01FF_FFFF};
    logic [31:0] exp_a;
    for (int i = 0; i < 3; i++) begin
      exp_a = adr[i] & 32'hFFFF_FFFC;
      issue(1'b1, {2'b00, sz[i]}, adr[i], wd[i]);
      checks++; if ({core_ARVALID, core_AWVALID, core_ARADDR} !== {2'b10, exp_a}) begin
        errors++; $display("FAIL rmw%0d_ar: got %b%b %h expected 10 %h", i, core_ARVALID, core_AWVALID, core_ARADDR, exp_a); end
      tick();
      core_RVALID = 1'b1; core_RDATA = rd[i];
      tick();
      core_RVALID = 1'b0; core_RDATA = 32'h5A5A_5A5A;
      checks++; if ({core_ARVALID, core_AWVALID, core_AWADDR, core_WDATA} !== {2'b01, exp_a, exp[i]}) begin
        errors++; $display("FAIL rmw%0d_aw: got %b%b %h %h expected 01 %h %h", i,
                           core_ARVALID, core_AWVALID, core_AWADDR, core_WDATA, exp_a, exp[i]); end
      tick();
      checks++; if ({core_AWVALID, resp_valid, core_WDATA} !== {2'b10, exp[i]}) begin
        errors++; $display("FAIL rmw%0d_hold: got %b%b %h expected 10 %h", i, core_AWVALID, resp_valid, core_WDATA, exp[i]); end
      core_BVALID = 1'b1;
      tick();
      core_BVALID = 1'b0;
      checks++; if ({resp_valid, resp_err, core_AWVALID, core_ARVALID, resp_rdata} !== {4'b1000, 32'd0}) begin
        errors++; $display("FAIL rmw%0d_resp: got %b%b%b%b %h expected 1000 0", i,
                           resp_valid, resp_err, core_AWVALID, core_ARVALID, resp_rdata); end
      tick();
      checks++; if ({resp_valid, req_ready} !== 2'b01) begin
        errors++; $display("FAIL rmw%0d_idle: got %b%b expected 01", i, resp_valid, req_ready); end
    end
  endtask

  task automatic test_sw_hold;
    issue(1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({core_AWVALID, core_ARVALID, resp_valid, core_AWADDR, core_WDATA} !== {3'b100, 32'h300, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL sw_hold%0d: got %b%b%b %h %h expected 100 00000300 deadbeef", i,
                           core_AWVALID, core_ARVALID, resp_valid, core_AWADDR, core_WDATA); end
      tick();
    end
    core_BVALID = 1'b1;
    tick();
    core_BVALID = 1'b0;
    checks++; if ({resp_valid, resp_err, core_AWVALID, core_WDATA} !== {3'b100, 32'd0}) begin
      errors++; $display("FAIL sw_resp: got %b%b%b %h expected 100 0", resp_valid, resp_err, core_AWVALID, core_WDATA); end
    tick();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL sw_idle: got %b%b expected 01", resp_valid, req_ready); end
  endtask

  task automatic test_errors;
    logic        we  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3  [7] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b100, 3'b110, 3'b010};
    logic [31:0] adr [7] = '{32'h102, 32'h101, 32'h201, 32'h100, 32'h100, 32'h100, 32'h103};
    for (int i = 0; i < 7; i++) begin
      issue(we[i], f3[i], adr[i], 32'h1234_5678);
      checks++; if ({resp_valid, resp_err, core_ARVALID, core_AWVALID, resp_rdata} !== {4'b1100, 32'd0}) begin
        errors++; $display("FAIL err%0d_resp: got %b%b%b%b %h expected 1100 0", i,
                           resp_valid, resp_err, core_ARVALID, core_AWVALID, resp_rdata); end
      tick();
      checks++; if ({resp_valid, resp_err, core_ARVALID, core_AWVALID, req_ready} !== 5'b00001) begin
        errors++; $display("FAIL err%0d_idle: got %b%b%b%b%b expected 00001", i,
                           resp_valid, resp_err, core_ARVALID, core_AWVALID, req_ready); end
    end
  endtask

  task automatic test_reset_abort;
    issue(1'b0, 3'b010, 32'h400, 32'd0);
    checks++; if (core_ARVALID !== 1'b1) begin errors++; $display("FAIL abort_ar: got %b expected 1", core_ARVALID); end
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    checks++; if ({core_ARVALID, resp_valid, req_ready, core_ARADDR} !== {3'b001, 32'd0}) begin
      errors++; $display("FAIL abort_reset: got %b%b%b %h expected 001 0", core_ARVALID, resp_valid, req_ready, core_ARADDR); end
    core_RVALID = 1'b1; core_RDATA = 32'hCAFE_0000;
    tick();
    core_RVALID = 1'b0;
    checks++; if ({resp_valid, req_ready, core_ARVALID, core_AWVALID} !== 4'b0100) begin
      errors++; $display("FAIL stray_rvalid: got %b%b%b%b expected 0100", resp_valid, req_ready, core_ARVALID, core_AWVALID); end
    core_BVALID = 1'b1;
    tick();
    core_BVALID = 1'b0;
    tick();
    checks++; if ({resp_valid, req_ready, core_ARVALID, core_AWVALID} !== 4'b0100) begin
      errors++; $display("FAIL stray_bvalid: got %b%b%b%b expected 0100", resp_valid, req_ready, core_ARVALID, core_AWVALID); end
  endtask

  task automatic test_no_overlap;
    checks++; if (both_seen !== 1'b0) begin
      errors++; $display("FAIL ar_aw_overlap: got %b expected 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_subword_rmw();
    test_sw_hold();
    test_errors();
    test_reset_abort();
    test_no_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the data cache port, between the pipeline MEM stage and the cache's core_AR/R/AW/W/B interface.
- Accepts one RV32 load/store per request and issues word-aligned cache reads and writes.
- Performs byte/half extraction with sign or zero extension on loads.
- The cache write path has no byte strobes, so sub-word stores are done as read-modify-write. The pipeline stalls on req_ready=0.

Parameters:
- CORE_ADDR_WIDTH, 32, byte address width to the pipeline and cache.
- CORE_DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 size/sign code.
- req_addr  in  CORE_ADDR_WIDTH  byte address.
- req_wdata  in  CORE_DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: transaction complete.
- resp_rdata  out  CORE_DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned access or illegal funct3.
- core_ARADDR  out  CORE_ADDR_WIDTH  word-aligned read address.
- core_ARVALID  out  1  read request.
- core_RDATA  in  CORE_DATA_WIDTH  read word.
- core_RVALID  in  1  read data valid, one-cycle pulse.
- core_AWADDR  out  CORE_ADDR_WIDTH  word-aligned write address.
- core_AWVALID  out  1  write request; core_WDATA is valid whenever it is high.
- core_WDATA  out  CORE_DATA_WIDTH  full write word.
- core_BVALID  in  1  write done, one-cycle pulse.

Behaviour:
- Reset: synchronous. All outputs go to 0 except req_ready=1; state returns to IDLE. Reset mid-transaction aborts on the next edge: valids drop and no resp_valid is produced. Stray RVALID/BVALID arriving in IDLE are ignored.
- On accept, the unit latches we, funct3, addr and wdata. Inputs are don't-care afterwards.
- States:
  - IDLE: req_ready=1.
  - RD: core_ARVALID=1.
  - RMW_RD: core_ARVALID=1.
  - WR: core_AWVALID=1.
  - RESP: resp_valid=1 for one cycle, then return to IDLE.
- Transitions from IDLE on accept:
  - Error case: misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 (load 011/110/111; store other than 000/001/010). Go to RESP with resp_err=1 and no bus activity.
  - Load: go to RD.
  - SW: go to WR with core_WDATA=wdata.
  - SB/SH: go to RMW_RD.
- RD: hold ARVALID until RVALID is sampled high, capture the extended data, then go to RESP.
- RMW_RD: on RVALID, merge the store bytes into core_RDATA at lane addr[1:0] (SB: 1 byte; SH: lanes 0-1 or 2-3), then go to WR.
- WR: hold AWVALID/WDATA stable until BVALID is sampled high, then go to RESP.
- ARVALID and AWVALID are never high together. Both drop the cycle after RVALID/BVALID is seen.
- Addresses: core_ARADDR = core_AWADDR = {addr[31:2],2'b00}. They are held stable while the corresponding valid is high and are 0 otherwise.
- Loads:
  - LB/LBU select byte addr[1:0], then sign- or zero-extend.
  - LH/LHU select half addr[1], then sign- or zero-extend.
  - LW returns the full word.
- Latency, with accept at cycle T:
  - Bus valid rises at T+1.
  - Response at one cycle after the RVALID/BVALID cycle.
  - Error response at T+1.
  - req_ready returns 1 in the cycle after RESP.

Optional Feature:
- Macro MAU_WORD_BUF_EN.
- Defined: adds a one-entry buffer holding {valid, word address, data} of the last word read or written.
  - A load hitting the valid buffer skips RD and goes straight to RESP, responding at T+1.
  - SB/SH hits skip RMW_RD and merge with the buffer.
  - Every completed read or write updates the buffer. Reset clears valid.
- Undefined: no buffer; every load and sub-word store issues a cache read.

Test Plan:
- LB addr 0x103, cache returns 0x80FF_1234 -> core_ARADDR=0x100, resp_rdata=0xFFFF_FF80, resp_err=0.
- LHU addr 0x102, RDATA 0xBEEF_0001 -> resp_rdata=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
- SB addr 0x201 wdata 0xAA, read returns 0x1122_3344 -> single AR then AW to 0x200 with WDATA 0x1122_AA44; resp_valid after BVALID.
- SW addr 0x300 wdata 0xDEAD_BEEF, BVALID delayed 5 cycles -> AWVALID and WDATA held stable 5 cycles, no ARVALID, resp_valid one cycle after BVALID.
- LW addr 0x102 -> resp_err=1 at T+1, no ARVALID/AWVALID ever asserted.
- Assert ARESET during RD, then pulse RVALID in IDLE -> no resp_valid, req_ready=1.
